// File: rtl/fp_operand_entry.sv
// Operand-entry front end for the FP ALU: builds A and B one hex digit at a time
// from switches plus a debounced ENTER, latches the op code, then issues under valid/ready.
module fp_operand_entry #(
  parameter  int DATA_WIDTH      = 32,
  parameter  int DEBOUNCE_CYCLES = 16,
  localparam int NIB             = DATA_WIDTH / 4,
  localparam int IDX_W           = (NIB > 1) ? $clog2(NIB) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            sw_nibble,
  input  logic [1:0]            sw_op,
  input  logic                  btn_enter,
  input  logic                  btn_clear,
  input  logic                  operands_ready,
  output logic [DATA_WIDTH-1:0] a,
  output logic [DATA_WIDTH-1:0] b,
  output logic [1:0]            operation,
  output logic                  operands_valid,
  output logic [1:0]            state_o,
  output logic [IDX_W-1:0]      digit_idx,
  output logic [DATA_WIDTH-1:0] entry_value
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {
    ENTER_A   = 2'b00,
    ENTER_B   = 2'b01,
    SELECT_OP = 2'b10,
    ISSUE     = 2'b11
  } state_t;

  // Button index 0 = ENTER, 1 = CLEAR.
  logic [1:0]       w_btn_raw;
  logic [1:0]       r_sync1, r_sync2, r_db, r_db_q;
  logic [CNT_W-1:0] r_cnt [2];
  logic             w_enter_pulse, w_clear_pulse;

  state_t                r_state, w_state_next;
  logic [DATA_WIDTH-1:0] r_shadow, r_a, r_b;
  logic [DATA_WIDTH-1:0] w_shifted;
  logic [IDX_W-1:0]      r_digit_idx;
  logic [1:0]            r_operation;
  logic                  r_valid;
  logic                  w_last_digit, w_shift, w_load_a, w_load_b, w_load_op, w_xfer;

  assign w_btn_raw = {btn_clear, btn_enter};

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values; blocking here would chain the synchronizer stages into one flop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_db    <= '0;
      r_db_q  <= '0;
      for (int i = 0; i < 2; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= w_btn_raw;
      r_sync2 <= r_sync1;
      r_db_q  <= r_db;
      for (int i = 0; i < 2; i++) begin
        if (r_sync2[i] != r_db[i]) begin
          if (r_cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
            r_db[i]  <= r_sync2[i];
            r_cnt[i] <= '0;
          end else begin
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
        end else begin
          r_cnt[i] <= '0;
        end
      end
    end
  end

  assign w_enter_pulse = r_db[0] & ~r_db_q[0];
  assign w_clear_pulse = r_db[1] & ~r_db_q[1];

  assign w_shifted    = {r_shadow[DATA_WIDTH-5:0], sw_nibble};
  assign w_last_digit = (r_digit_idx == IDX_W'(NIB - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ENTER_A;
    else       r_state <= w_state_next;
  end

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    w_state_next = r_state;
    w_shift      = 1'b0;
    w_load_a     = 1'b0;
    w_load_b     = 1'b0;
    w_load_op    = 1'b0;
    w_xfer       = 1'b0;
    if (w_clear_pulse) begin
      w_state_next = ENTER_A;
    end else begin
      unique case (r_state)
        ENTER_A: if (w_enter_pulse) begin
          w_shift = 1'b1;
          if (w_last_digit) begin
            w_load_a     = 1'b1;
            w_state_next = ENTER_B;
          end
        end
        ENTER_B: if (w_enter_pulse) begin
          w_shift = 1'b1;
          if (w_last_digit) begin
            w_load_b     = 1'b1;
            w_state_next = SELECT_OP;
          end
        end
        SELECT_OP: if (w_enter_pulse) begin
          w_load_op    = 1'b1;
          w_state_next = ISSUE;
        end
        ISSUE: if (r_valid && operands_ready) begin
          w_xfer       = 1'b1;
          w_state_next = ENTER_A;
        end
        default: w_state_next = ENTER_A;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow    <= '0;
      r_digit_idx <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_operation <= '0;
      r_valid     <= 1'b0;
    end else if (w_clear_pulse) begin
      // Committed a/b/operation survive a clear so the display can still show them.
      r_shadow    <= '0;
      r_digit_idx <= '0;
      r_valid     <= 1'b0;
    end else begin
      if (w_shift) begin
        if (w_last_digit) begin
          r_shadow    <= '0;
          r_digit_idx <= '0;
        end else begin
          r_shadow    <= w_shifted;
          r_digit_idx <= r_digit_idx + IDX_W'(1);
        end
      end
      if (w_load_a) r_a <= w_shifted;
      if (w_load_b) r_b <= w_shifted;
      if (w_load_op) begin
        r_operation <= sw_op;
        r_valid     <= 1'b1;
      end
      if (w_xfer) r_valid <= 1'b0;
    end
  end

  assign a              = r_a;
  assign b              = r_b;
  assign operation      = r_operation;
  assign operands_valid = r_valid;
  assign state_o        = r_state;
  assign digit_idx      = r_digit_idx;
  assign entry_value    = r_shadow;

endmodule

// File: tb/tb_fp_operand_entry.sv
// Self-checking bench for fp_operand_entry: scoreboard of issued operand sets plus
// per-scenario checks of entry, debounce, clear and reset behaviour.
module tb_fp_operand_entry;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sw_nibble;
  logic [1:0]  sw_op;
  logic        btn_enter, btn_clear, operands_ready;
  logic [31:0] a, b, entry_value;
  logic [1:0]  operation, state_o;
  logic        operands_valid;
  logic [2:0]  digit_idx;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } txn_t;

  txn_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  fp_operand_entry #(.DATA_WIDTH(32), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .sw_nibble(sw_nibble), .sw_op(sw_op),
    .btn_enter(btn_enter), .btn_clear(btn_clear), .operands_ready(operands_ready),
    .a(a), .b(b), .operation(operation), .operands_valid(operands_valid),
    .state_o(state_o), .digit_idx(digit_idx), .entry_value(entry_value)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_enter(input logic [3:0] nib);
    sw_nibble = nib;
    btn_enter = 1'b1;
    tick(8);
    btn_enter = 1'b0;
    tick(8);
  endtask

  task automatic press_clear();
    btn_clear = 1'b1;
    tick(8);
    btn_clear = 1'b0;
    tick(8);
  endtask

  task automatic enter_word(input logic [31:0] w);
    for (int i = 7; i >= 0; i--) press_enter(w[i*4 +: 4]);
  endtask

  // Pops the scoreboard at the negedge just before the transfer edge.
  task automatic wait_transfer(input int budget);
    int   k;
    txn_t exp_t;
    k = 0;
    while (!(operands_valid && operands_ready) && k < budget) begin
      @(negedge clk);
      k++;
    end
    n_tests++;
    if (!(operands_valid && operands_ready)) begin
      n_fail++;
      $display("FAIL transfer_timeout: valid=%0b ready=%0b after %0d cycles, required handshake",
               operands_valid, operands_ready, budget);
    end else if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL transfer_unexpected: a=%h b=%h op=%0d, scoreboard empty", a, b, operation);
    end else begin
      exp_t = sb_q.pop_front();
      if (a !== exp_t.a || b !== exp_t.b || operation !== exp_t.op) begin
        n_fail++;
        $display("FAIL transfer_data: got a=%h b=%h op=%0d, expected a=%h b=%h op=%0d",
                 a, b, operation, exp_t.a, exp_t.b, exp_t.op);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; sw_nibble = '0; sw_op = '0;
    btn_enter = 1'b0; btn_clear = 1'b0; operands_ready = 1'b0;
    tick(3);
    n_tests++;
    if ({a, b, operation, operands_valid, state_o, digit_idx, entry_value} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: a=%h b=%h op=%0d v=%0b st=%0d idx=%0d ev=%h, expected all zero",
               a, b, operation, operands_valid, state_o, digit_idx, entry_value);
    end
    reset = 1'b0;
    tick(2);
  endtask

  task automatic test_entry_issue();
    enter_word(32'h4144CCCD);
    n_tests++;
    if (a !== 32'h4144CCCD || state_o !== 2'b01) begin
      n_fail++;
      $display("FAIL commit_a: a=%h st=%0d, expected 4144cccd st=1", a, state_o);
    end
    press_enter(4'h4); press_enter(4'h0); press_enter(4'h5);
    n_tests++;
    if (entry_value !== 32'h405 || digit_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL partial_b: ev=%h idx=%0d, expected 405 idx=3", entry_value, digit_idx);
    end
    press_enter(4'h9); press_enter(4'h9); press_enter(4'h9);
    press_enter(4'h9); press_enter(4'hA);
    n_tests++;
    if (b !== 32'h4059999A || state_o !== 2'b10 || entry_value !== '0) begin
      n_fail++;
      $display("FAIL commit_b: b=%h st=%0d ev=%h, expected 4059999a st=2 ev=0", b, state_o, entry_value);
    end
    sw_op = 2'b00;
    sb_q.push_back('{a: 32'h4144CCCD, b: 32'h4059999A, op: 2'b00});
    press_enter(4'h0);
    n_tests++;
    if (operands_valid !== 1'b1 || state_o !== 2'b11) begin
      n_fail++;
      $display("FAIL issue_enter: valid=%0b st=%0d, expected valid=1 st=3", operands_valid, state_o);
    end
    for (int i = 0; i < 5; i++) begin
      tick(1);
      n_tests++;
      if (operands_valid !== 1'b1 || a !== 32'h4144CCCD || b !== 32'h4059999A || operation !== 2'b00) begin
        n_fail++;
        $display("FAIL hold_stable[%0d]: valid=%0b a=%h b=%h op=%0d, expected held values",
                 i, operands_valid, a, b, operation);
      end
    end
    press_enter(4'hF);
    n_tests++;
    if (state_o !== 2'b11 || operands_valid !== 1'b1 || entry_value !== '0) begin
      n_fail++;
      $display("FAIL issue_ignores_enter: st=%0d valid=%0b ev=%h, expected st=3 valid=1 ev=0",
               state_o, operands_valid, entry_value);
    end
    operands_ready = 1'b1;
    wait_transfer(5);
    tick(1);
    operands_ready = 1'b0;
    n_tests++;
    if (operands_valid !== 1'b0 || state_o !== 2'b00) begin
      n_fail++;
      $display("FAIL after_transfer: valid=%0b st=%0d, expected valid=0 st=0", operands_valid, state_o);
    end
  endtask

  task automatic test_glitch();
    sw_nibble = 4'h3;
    btn_enter = 1'b1; tick(3); btn_enter = 1'b0; tick(10);
    n_tests++;
    if (digit_idx !== 3'd0 || entry_value !== '0) begin
      n_fail++;
      $display("FAIL glitch_rejected: idx=%0d ev=%h, expected idx=0 ev=0", digit_idx, entry_value);
    end
    sw_nibble = 4'h7;
    btn_enter = 1'b1; tick(6); btn_enter = 1'b0; tick(10);
    n_tests++;
    if (digit_idx !== 3'd1 || entry_value !== 32'h7) begin
      n_fail++;
      $display("FAIL short_press: idx=%0d ev=%h, expected idx=1 ev=7", digit_idx, entry_value);
    end
  endtask

  task automatic test_held_bounce();
    sw_nibble = 4'h2;
    for (int i = 0; i < 4; i++) begin
      btn_enter = ~btn_enter;
      tick(1);
    end
    btn_enter = 1'b1; tick(100); btn_enter = 1'b0; tick(10);
    n_tests++;
    if (digit_idx !== 3'd2 || entry_value !== 32'h72) begin
      n_fail++;
      $display("FAIL held_one_pulse: idx=%0d ev=%h, expected idx=2 ev=72", digit_idx, entry_value);
    end
  endtask

  task automatic test_clear();
    press_clear();
    n_tests++;
    if (digit_idx !== 3'd0 || entry_value !== '0 || state_o !== 2'b00) begin
      n_fail++;
      $display("FAIL clear_in_a: idx=%0d ev=%h st=%0d, expected 0/0/0", digit_idx, entry_value, state_o);
    end
    enter_word(32'h4144CCCD);
    press_enter(4'h4); press_enter(4'h0); press_enter(4'h5);
    press_enter(4'h9); press_enter(4'h9);
    n_tests++;
    if (digit_idx !== 3'd5 || entry_value !== 32'h40599 || state_o !== 2'b01) begin
      n_fail++;
      $display("FAIL five_b_digits: idx=%0d ev=%h st=%0d, expected 5/40599/1", digit_idx, entry_value, state_o);
    end
    press_clear();
    n_tests++;
    if (state_o !== 2'b00 || digit_idx !== 3'd0 || entry_value !== '0 || a !== 32'h4144CCCD) begin
      n_fail++;
      $display("FAIL clear_in_b: st=%0d idx=%0d ev=%h a=%h, expected 0/0/0/4144cccd",
               state_o, digit_idx, entry_value, a);
    end
  endtask

  task automatic test_clear_enter_same();
    enter_word(32'h11223344);
    press_enter(4'h4); press_enter(4'h0);
    n_tests++;
    if (state_o !== 2'b01 || digit_idx !== 3'd2 || entry_value !== 32'h40) begin
      n_fail++;
      $display("FAIL pre_same_cycle: st=%0d idx=%0d ev=%h, expected 1/2/40", state_o, digit_idx, entry_value);
    end
    sw_nibble = 4'hE;
    btn_enter = 1'b1; btn_clear = 1'b1;
    tick(8);
    btn_enter = 1'b0; btn_clear = 1'b0;
    tick(8);
    n_tests++;
    if (state_o !== 2'b00 || digit_idx !== 3'd0 || entry_value !== '0 ||
        a !== 32'h11223344 || b !== 32'h4059999A) begin
      n_fail++;
      $display("FAIL clear_wins: st=%0d idx=%0d ev=%h a=%h b=%h, expected 0/0/0/11223344/4059999a",
               state_o, digit_idx, entry_value, a, b);
    end
  endtask

  task automatic test_back_to_back();
    operands_ready = 1'b1;
    enter_word(32'h3F800000);
    n_tests++;
    if (state_o !== 2'b01 || a !== 32'h3F800000) begin
      n_fail++;
      $display("FAIL ready_no_effect_a: st=%0d a=%h, expected 1/3f800000", state_o, a);
    end
    enter_word(32'h40000000);
    sw_op = 2'b11;
    sb_q.push_back('{a: 32'h3F800000, b: 32'h40000000, op: 2'b11});
    sw_nibble = 4'h0;
    btn_enter = 1'b1;
    wait_transfer(40);
    btn_enter = 1'b0;
    tick(10);
    operands_ready = 1'b0;
    n_tests++;
    if (operands_valid !== 1'b0 || state_o !== 2'b00 || operation !== 2'b11) begin
      n_fail++;
      $display("FAIL immediate_transfer: valid=%0b st=%0d op=%0d, expected 0/0/3",
               operands_valid, state_o, operation);
    end
  endtask

  task automatic test_async_reset();
    enter_word(32'hC0000000);
    enter_word(32'h3F000000);
    sw_op = 2'b10;
    press_enter(4'h0);
    n_tests++;
    if (operands_valid !== 1'b1 || state_o !== 2'b11 || operation !== 2'b10) begin
      n_fail++;
      $display("FAIL pre_reset_issue: valid=%0b st=%0d op=%0d, expected 1/3/2",
               operands_valid, state_o, operation);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (operands_valid !== 1'b0 || a !== '0 || b !== '0 || operation !== 2'b00 || state_o !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset: valid=%0b a=%h b=%h op=%0d st=%0d, expected all zero",
               operands_valid, a, b, operation, state_o);
    end
    tick(2);
    reset = 1'b0;
    tick(2);
    n_tests++;
    if (sb_q.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_entry_issue();
    test_glitch();
    test_held_bounce();
    test_clear();
    test_clear_enter_same();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
